alu_issue_stage: RTL and testbench

//  Producer side of the ALU operand/opcode interface. Decodes an RV32I instruction into

---
 rtl/alu_issue_stage_pkg.sv | 61 ++++++
 rtl/alu_issue_stage_imm_gen.sv | 17 +
 rtl/alu_issue_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALUOp codes, RV32I opcode constants and the ID/EX payload layout.
package alu_issue_stage_pkg;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_SLL     = 4'd2;
    localparam logic [3:0] ALU_SRL     = 4'd3;
    localparam logic [3:0] ALU_SRA     = 4'd4;
    localparam logic [3:0] ALU_XOR     = 4'd5;
    localparam logic [3:0] ALU_OR      = 4'd6;
    localparam logic [3:0] ALU_AND     = 4'd7;
    localparam logic [3:0] ALU_SEQ     = 4'd8;
    localparam logic [3:0] ALU_SNE     = 4'd9;
    localparam logic [3:0] ALU_SLT     = 4'd10;
    localparam logic [3:0] ALU_SGE     = 4'd11;
    localparam logic [3:0] ALU_SLTU    = 4'd12;
    localparam logic [3:0] ALU_SGEU    = 4'd13;
    localparam logic [3:0] ALU_ILLEGAL = 4'd15;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] store_data;
        logic [31:0] target;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } issue_payload_t;

    // funct3 map shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_imm_gen.sv
// Sign-extended RV32I immediates; opcode bits are not needed so only instr[31:7] enters.
module alu_issue_stage_imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode to ALUOp/operands/target, held in a single ID/EX register with valid/ready.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter logic [3:0]  ILLEGAL_OP = ALU_ILLEGAL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] store_data,
    output logic            is_branch,
    output logic            is_jump,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;

    issue_payload_t dec, payload_q;
    logic           valid_q;
    logic           legal, is_jalr;
    logic [31:0]    tgt_base, tgt_off, tgt_sum;

    alu_issue_stage_imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        is_jalr  = 1'b0;
        tgt_base = pc;
        tgt_off  = imm_b;
        tgt_sum  = '0;

        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec.op1    = rs1_data;
                    dec.op2    = rs2_data;
                    dec.alu_op = arith_op(f3, f7[5]);
                    legal      = (f7 == F7_BASE) ||
                                 ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                end
                OPC_OP_IMM: begin
                    dec.op1    = rs1_data;
                    dec.op2    = imm_i;
                    dec.alu_op = arith_op(f3, (f3 == 3'b101) && f7[5]);
                    // Shift immediates carry funct7 in the upper imm bits.
                    if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                        dec.op2 = {27'b0, instr[24:20]};
                        legal   = (f7 == F7_BASE) || ((f3 == 3'b101) && (f7 == F7_ALT));
                    end
                end
                OPC_LOAD: begin
                    dec.op1 = rs1_data;
                    dec.op2 = imm_i;
                end
                OPC_STORE: begin
                    dec.op1        = rs1_data;
                    dec.op2        = imm_s;
                    dec.store_data = rs2_data;
                end
                OPC_BRANCH: begin
                    dec.op1       = rs1_data;
                    dec.op2       = rs2_data;
                    dec.is_branch = 1'b1;
                    case (f3)
                        3'b000:  dec.alu_op = ALU_SEQ;
                        3'b001:  dec.alu_op = ALU_SNE;
                        3'b100:  dec.alu_op = ALU_SLT;
                        3'b101:  dec.alu_op = ALU_SGE;
                        3'b110:  dec.alu_op = ALU_SLTU;
                        3'b111:  dec.alu_op = ALU_SGEU;
                        default: legal      = 1'b0;
                    endcase
                end
                OPC_LUI: begin
                    dec.op2 = imm_u;
                end
                OPC_AUIPC: begin
                    dec.op1 = pc;
                    dec.op2 = imm_u;
                end
                OPC_JAL: begin
                    dec.op1     = pc;
                    dec.op2     = 32'd4;
                    dec.is_jump = 1'b1;
                    tgt_off     = imm_j;
                end
                OPC_JALR: begin
                    dec.op1     = pc;
                    dec.op2     = 32'd4;
                    dec.is_jump = 1'b1;
                    tgt_base    = rs1_data;
                    tgt_off     = imm_i;
                    is_jalr     = 1'b1;
                    legal       = (f3 == 3'b000);
                end
                default: legal = 1'b0;
            endcase
        end

        tgt_sum = tgt_base + tgt_off;
        if (dec.is_branch || dec.is_jump) begin
            dec.target = {tgt_sum[31:1], tgt_sum[0] & ~is_jalr};
        end

        if (!legal) begin
            dec         = '0;
            dec.alu_op  = ILLEGAL_OP;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Flush squashes both the held entry and a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q   <= 1'b1;
            payload_q <= dec;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign alu_op     = payload_q.alu_op;
    assign op1        = payload_q.op1;
    assign op2        = payload_q.op2;
    assign store_data = payload_q.store_data;
    assign target     = payload_q.target;
    assign is_branch  = payload_q.is_branch;
    assign is_jump    = payload_q.is_jump;
    assign illegal    = payload_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench: mnemonic-level reference model plus per-cycle compare and literal spot checks.
module tb_alu_issue_stage;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic        br;
        logic        jp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2, store_data, target;
    logic        is_branch, is_jump, illegal;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    string alu_names[14] = '{"add", "sub", "sll", "srl", "sra", "xor", "or", "and",
                             "seq", "sne", "slt", "sge", "sltu", "sgeu"};
    string rr_names[8]  = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    string br_names[8]  = '{"seq", "sne", "bad", "bad", "slt", "sge", "sltu", "sgeu"};

    alu_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .op1        (op1),
        .op2        (op2),
        .store_data (store_data),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .target     (target),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: name the instruction first, then derive operands from its mnemonic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        string  m = "bad";
        int     f3 = int'(ins[14:12]);
        int     f7 = int'(ins[31:25]);
        logic signed [11:0] i12 = ins[31:20];
        logic signed [11:0] s12 = {ins[31:25], ins[11:7]};
        logic signed [12:0] b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic signed [20:0] j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        int     iimm = int'(i12);
        e = '{op: 4'd0, op1: 0, op2: 0, sd: 0, tgt: 0, br: 0, jp: 0, ill: 0};
        case (ins[6:0])
            7'h33: begin
                if (f7 == 0) m = rr_names[f3];
                else if (f7 == 32 && f3 == 0) m = "sub";
                else if (f7 == 32 && f3 == 5) m = "sra";
                e.op1 = a; e.op2 = b;
            end
            7'h13: begin
                e.op1 = a;
                if (f3 == 1 || f3 == 5) begin
                    e.op2 = 32'(ins[24:20]);
                    if (f7 == 0) m = rr_names[f3];
                    else if (f7 == 32 && f3 == 5) m = "sra";
                end else begin
                    e.op2 = iimm;
                    m = rr_names[f3];
                end
            end
            7'h03: begin m = "add"; e.op1 = a; e.op2 = iimm; end
            7'h23: begin m = "add"; e.op1 = a; e.op2 = int'(s12); e.sd = b; end
            7'h63: begin
                m = br_names[f3]; e.op1 = a; e.op2 = b; e.br = 1;
                e.tgt = p + int'(b13);
            end
            7'h37: begin m = "add"; e.op2 = {ins[31:12], 12'h000}; end
            7'h17: begin m = "add"; e.op1 = p; e.op2 = {ins[31:12], 12'h000}; end
            7'h6F: begin
                m = "add"; e.op1 = p; e.op2 = 4; e.jp = 1; e.tgt = p + int'(j21);
            end
            7'h67: begin
                if (f3 == 0) m = "add";
                e.op1 = p; e.op2 = 4; e.jp = 1; e.tgt = (a + iimm) & ~32'd1;
            end
            default: m = "bad";
        endcase
        if (ins[1:0] != 2'b11) m = "bad";
        if (m == "bad") begin
            e = '{op: 4'd15, op1: 0, op2: 0, sd: 0, tgt: 0, br: 0, jp: 0, ill: 1};
        end else begin
            for (int k = 0; k < 14; k++) if (alu_names[k] == m) e.op = 4'(k);
        end
        return e;
    endfunction

    // Stage model: at most one entry outstanding.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && (q.size() == 0 || out_ready) && !flush) begin
                if (q.size() != 0) void'(q.pop_front());
                q.push_back(model(instr, pc, rs1_data, rs2_data));
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (flush) q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("alu_op", 32'(alu_op), 32'(q[0].op));
                check("op1", op1, q[0].op1);
                check("op2", op2, q[0].op2);
                check("store_data", store_data, q[0].sd);
                check("target", target, q[0].tgt);
                check("flags", {29'd0, is_branch, is_jump, illegal},
                      {29'd0, q[0].br, q[0].jp, q[0].ill});
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
        instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] vec[14] = '{
        32'h402081B3, 32'h022081B3, 32'h40409093, 32'hFFF0A093, 32'h0020A423,
        32'h010000EF, 32'h123452B7, 32'h00001097, 32'hFE20ACE3, 32'h00004501,
        32'h4020D1B3, 32'hFFC12083, 32'h000290E7, 32'h0020D463
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst alu_op", 32'(alu_op), 32'd0);
        check("rst op1", op1, 32'd0);
        check("rst target", target, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("add valid", 32'(out_valid), 32'd1);
        check("add op", 32'(alu_op), 32'd0);
        check("add op1", op1, 32'd5);
        check("add op2", op2, 32'd7);

        send(32'h4040D093, 32'h4, 32'h80000000, 32'h0);
        check("srai op", 32'(alu_op), 32'd4);
        check("srai op2", op2, 32'd4);
        check("srai illegal", 32'(illegal), 32'd0);

        send(32'hFE20ECE3, 32'h100, 32'd1, 32'd2);
        check("bltu op", 32'(alu_op), 32'd12);
        check("bltu br", 32'(is_branch), 32'd1);
        check("bltu target", target, 32'h0F8);

        send(32'h000280E7, 32'h40, 32'h203, 32'h0);
        check("jalr op1", op1, 32'h40);
        check("jalr op2", op2, 32'd4);
        check("jalr target", target, 32'h202);
        check("jalr jump", 32'(is_jump), 32'd1);

        send(32'h0000007F, 32'h44, 32'h1, 32'h2);
        check("bad illegal", 32'(illegal), 32'd1);
        check("bad op", 32'(alu_op), 32'd15);

        for (int i = 0; i < 14; i++) begin
            send(vec[i], 32'h1000 + 32'(4 * i), 32'hF0000000 + 32'(i), 32'h1234 + 32'(i));
        end
        @(posedge clk);
        #1;

        // Back-pressure: hold the lui entry for three cycles with a pending input.
        out_ready = 1'b0;
        send(32'h123452B7, 32'h200, 32'h0, 32'h0);
        instr = 32'h00001097; pc = 32'h204; rs1_data = 32'h0; rs2_data = 32'h0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall op2", op2, 32'h12345000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release op1", op1, 32'h204);
        send(32'h002081B3, 32'h208, 32'd9, 32'd3);
        check("stream valid", 32'(out_valid), 32'd1);
        send(32'h402081B3, 32'h20C, 32'd9, 32'd3);
        check("stream op", 32'(alu_op), 32'd1);

        // Flush with a held entry and a same-cycle accept.
        instr = 32'h0020A423; pc = 32'h210; rs1_data = 32'h10; rs2_data = 32'hAB;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("after flush valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
